// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with a two-entry skid buffer.
// The stage carries a control and a data bundle under a valid/ready handshake.
// in_ready depends only on local state, freeze and flush; it never depends on out_ready.
// Freeze holds every register.
// A flush raised while frozen is remembered and applied on the first unfrozen cycle.
module pipe_stage_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CTRL_W     = 8,
  parameter int unsigned CNT_W      = 16,
  parameter bit          CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              flush_pend;
  logic              accept;
  logic              drain;
  logic              eff_flush;

  // State register: reset has priority over everything else
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: freeze holds, then flush empties, then handshake moves
  always_comb begin
    state_nxt = state;
    if (freeze) begin
      state_nxt = state;
    end else if (eff_flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY:   if (accept) state_nxt = BUSY;
        BUSY: begin
          if (accept && !drain)      state_nxt = FULL;
          else if (!accept && drain) state_nxt = EMPTY;
        end
        FULL:    if (drain) state_nxt = BUSY;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Output and handshake decode; in_ready uses only local state, freeze and flush
  always_comb begin
    out_valid = (state != EMPTY);
    in_ready  = (state != FULL) && !freeze && !flush && !flush_pend;
    eff_flush = (flush || flush_pend) && !freeze;
    accept    = in_valid && in_ready;
    drain     = out_valid && out_ready && !freeze;
  end

  // Main, skid and pending-flush registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_ctrl   <= '0;
      out_data   <= '0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
      flush_pend <= 1'b0;
    end else if (freeze) begin
      if (flush) flush_pend <= 1'b1;
    end else if (eff_flush) begin
      out_ctrl   <= '0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
      flush_pend <= 1'b0;
      if (CLEAR_DATA) out_data <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            out_ctrl <= in_ctrl;
            out_data <= in_data;
          end
        end
        BUSY: begin
          if (accept && drain) begin
            out_ctrl <= in_ctrl;
            out_data <= in_data;
          end else if (accept) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
          end else if (drain) begin
            out_ctrl <= '0;
            if (CLEAR_DATA) out_data <= '0;
          end
        end
        FULL: begin
          if (drain) begin
            out_ctrl <= skid_ctrl;
            out_data <= skid_data;
          end
        end
        default: begin
          out_ctrl <= '0;
        end
      endcase
    end
  end

  // Saturating count of cycles where downstream was ready but nothing was offered
  always_ff @(posedge clk) begin
    if (!reset) begin
      bubble_cnt <= '0;
    end else if (!freeze && !out_valid && out_ready && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg.
// It applies a vector table for streaming, backpressure and flush.
// Hand-written sequences cover freeze with a pending flush, bubble counting and saturation, and reset while frozen.
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, flush, freeze, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [15:0]   bubble_cnt;

  logic          s_in_ready, s_out_valid;
  logic [CW-1:0] s_out_ctrl;
  logic [DW-1:0] s_out_data;
  logic [2:0]    s_bubble_cnt;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16), .CLEAR_DATA(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(3), .CLEAR_DATA(1'b1)) dut_small (
    .clk(clk), .reset(reset), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
    .bubble_cnt(s_bubble_cnt)
  );

  typedef struct {
    logic          rst, fl, fz, iv;
    logic [CW-1:0] ic;
    logic [DW-1:0] id;
    logic          ordy;
    logic          chk_ir;
    logic          ir;
    logic          ov;
    logic [CW-1:0] oc;
    logic [DW-1:0] od;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(logic rst, logic fl, logic fz, logic iv, logic [CW-1:0] ic,
                              logic [DW-1:0] id, logic ordy, logic chk_ir, logic ir,
                              logic ov, logic [CW-1:0] oc, logic [DW-1:0] od);
    vec_t v;
    v.rst = rst; v.fl = fl; v.fz = fz; v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy;
    v.chk_ir = chk_ir; v.ir = ir; v.ov = ov; v.oc = oc; v.od = od;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic fl, input logic fz, input logic iv,
                       input logic [CW-1:0] ic, input logic [DW-1:0] id, input logic ordy);
    reset = rst; flush = fl; freeze = fz; in_valid = iv; in_ctrl = ic; in_data = id;
    out_ready = ordy;
  endtask

  task automatic chk_out(input string nm, input logic ov, input logic [CW-1:0] oc,
                         input logic [DW-1:0] od);
    chk({nm, " out_valid"}, 32'(out_valid), 32'(ov));
    chk({nm, " out_ctrl"},  32'(out_ctrl),  32'(oc));
    chk({nm, " out_data"},  out_data,       od);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

    // Reset, then idle
    vecs.push_back(mk(0,0,0,0, 8'h00, 32'h0, 0, 0,0, 0, 8'h00, 32'h0));
    vecs.push_back(mk(1,0,0,0, 8'h00, 32'h0, 1, 1,1, 0, 8'h00, 32'h0));
    // Stream 1..8 with out_ready high: each appears one cycle after accept
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(1,0,0,1, 8'(8'h10 + k), 32'(k), 1, 1,1, 1, 8'(8'h10 + k), 32'(k)));
    vecs.push_back(mk(1,0,0,0, 8'h00, 32'h0, 1, 1,1, 0, 8'h00, 32'h0));
    // Backpressure: A, B fill the stage, C waits upstream until drain
    vecs.push_back(mk(1,0,0,1, 8'h01, 32'h11, 1, 1,1, 1, 8'h01, 32'h11));
    vecs.push_back(mk(1,0,0,1, 8'h02, 32'h22, 0, 1,1, 1, 8'h01, 32'h11));
    vecs.push_back(mk(1,0,0,1, 8'h03, 32'h33, 0, 1,0, 1, 8'h01, 32'h11));
    vecs.push_back(mk(1,0,0,1, 8'h03, 32'h33, 1, 1,0, 1, 8'h02, 32'h22));
    vecs.push_back(mk(1,0,0,1, 8'h03, 32'h33, 1, 1,1, 1, 8'h03, 32'h33));
    vecs.push_back(mk(1,0,0,0, 8'h00, 32'h0,  1, 1,1, 0, 8'h00, 32'h0));
    // Flush while FULL with 0xFF in the skid; the skid entry never emerges
    vecs.push_back(mk(1,0,0,1, 8'h04, 32'h44, 0, 1,1, 1, 8'h04, 32'h44));
    vecs.push_back(mk(1,0,0,1, 8'hFF, 32'h55, 0, 1,1, 1, 8'h04, 32'h44));
    vecs.push_back(mk(1,1,0,1, 8'hFF, 32'h66, 0, 1,0, 0, 8'h00, 32'h0));
    vecs.push_back(mk(1,0,0,0, 8'h00, 32'h0,  1, 1,1, 0, 8'h00, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].fz, vecs[i].iv, vecs[i].ic, vecs[i].id, vecs[i].ordy);
      #1;
      if (vecs[i].chk_ir) chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].ir));
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].ov, vecs[i].oc, vecs[i].od);
    end

    // Freeze for three cycles with flush pulsed on the second frozen cycle
    drive(1, 0, 0, 1, 8'h07, 32'h77, 0);
    tick();
    chk_out("frz load", 1, 8'h07, 32'h77);
    for (int c = 0; c < 3; c++) begin
      drive(1, (c == 1), 1, 1, 8'h08, 32'h88, 1);
      #1;
      chk($sformatf("frz%0d in_ready", c), 32'(in_ready), 32'd0);
      tick();
      chk_out($sformatf("frz%0d", c), 1, 8'h07, 32'h77);
    end
    drive(1, 0, 0, 1, 8'h08, 32'h88, 0);
    #1;
    chk("unfrz in_ready", 32'(in_ready), 32'd0);
    tick();
    chk_out("unfrz flushed", 0, 8'h00, 32'h0);
    chk("post-flush in_ready", 32'(in_ready), 32'd1);

    // Bubble counting: 3 counted cycles, 2 frozen, then 7 more counted
    drive(0, 0, 0, 0, '0, '0, 1);
    tick();
    chk("bub rst", 32'(bubble_cnt), 32'd0);
    chk("bub3 rst", 32'(s_bubble_cnt), 32'd0);
    drive(1, 0, 0, 0, '0, '0, 1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("bub c%0d", k), 32'(bubble_cnt), 32'(k));
      chk($sformatf("bub3 c%0d", k), 32'(s_bubble_cnt), 32'(k));
    end
    freeze = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("bub frz%0d", k), 32'(bubble_cnt), 32'd3);
      chk($sformatf("bub3 frz%0d", k), 32'(s_bubble_cnt), 32'd3);
    end
    freeze = 1'b0;
    for (int k = 4; k <= 10; k++) begin
      tick();
      chk($sformatf("bub c%0d", k), 32'(bubble_cnt), 32'(k));
      chk($sformatf("bub3 c%0d", k), 32'(s_bubble_cnt), 32'((k > 7) ? 7 : k));
    end

    // Reset while FULL and frozen
    drive(1, 0, 0, 1, 8'h0A, 32'hA0, 0);
    tick();
    drive(1, 0, 0, 1, 8'h0B, 32'hB0, 0);
    tick();
    drive(1, 0, 1, 1, 8'h0C, 32'hC0, 0);
    #1;
    reset = 1'b0;
    #1;
    chk_out("rst no edge", 1, 8'h0A, 32'hA0);
    chk("rst no edge bub", 32'(bubble_cnt), 32'd10);
    tick();
    chk_out("rst frz", 0, 8'h00, 32'h0);
    chk("rst frz bub", 32'(bubble_cnt), 32'd0);
    drive(1, 0, 0, 0, '0, '0, 0);
    #1;
    chk("rst release in_ready", 32'(in_ready), 32'd1);
    chk_out("rst release", 0, 8'h00, 32'h0);
    tick();
    chk_out("after rst idle", 0, 8'h00, 32'h0);
    chk("after rst bub", 32'(bubble_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
